// File: rtl/fir_complex_interp_if.sv
// I/Q sample FIFO pair (read side) and filtered output FIFO pair (write side)
// seen by the complex interpolating FIR.
interface fir_complex_interp_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] i_in;
  logic                  i_empty;
  logic                  i_rd_en;
  logic [DATA_WIDTH-1:0] q_in;
  logic                  q_empty;
  logic                  q_rd_en;
  logic [DATA_WIDTH-1:0] real_out;
  logic                  real_wr_en;
  logic                  real_full;
  logic [DATA_WIDTH-1:0] imag_out;
  logic                  imag_wr_en;
  logic                  imag_full;

  modport master (
    output i_in, i_empty, q_in, q_empty, real_full, imag_full,
    input  i_rd_en, q_rd_en, real_out, real_wr_en, imag_out, imag_wr_en
  );

  modport slave (
    input  i_in, i_empty, q_in, q_empty, real_full, imag_full,
    output i_rd_en, q_rd_en, real_out, real_wr_en, imag_out, imag_wr_en
  );
endinterface

// File: rtl/fir_complex_interp.sv
// Complex polyphase interpolating FIR: each I/Q input pair yields INTERP filtered
// I/Q output pairs, one complex MAC per cycle over TAP_NUMBER/INTERP taps per phase.
module fir_complex_interp #(
  parameter int INTERP     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAP_NUMBER = 20,
  parameter int FRAC_BITS  = 10,
  parameter logic [TAP_NUMBER-1:0][DATA_WIDTH-1:0] REAL_COEFF =
    {{((TAP_NUMBER - 1) * DATA_WIDTH){1'b0}}, DATA_WIDTH'(32'h0000_0400)},
  parameter logic [TAP_NUMBER-1:0][DATA_WIDTH-1:0] IMAG_COEFF = '0
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  fir_complex_interp_if.slave io
);

  localparam int TPP = TAP_NUMBER / INTERP;
  localparam int PW  = (INTERP > 1) ? $clog2(INTERP) : 1;
  localparam int TW  = (TPP > 1) ? $clog2(TPP) : 1;
  localparam int KW  = (TAP_NUMBER > 1) ? $clog2(TAP_NUMBER) : 1;

  typedef enum logic [1:0] {
    ST_READ  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Q-format product: full-width signed multiply, arithmetic shift (floor), truncate.
  function automatic logic [DATA_WIDTH-1:0] mul_q(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    logic signed [2*DATA_WIDTH-1:0] p;
    p = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) *
        $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
    return DATA_WIDTH'(p >>> FRAC_BITS);
  endfunction

  state_e                         state_q;
  logic [PW-1:0]                  phase_q;
  logic [TW-1:0]                  tap_q;
  logic [DATA_WIDTH-1:0]          acc_r_q, acc_i_q;
  logic [DATA_WIDTH-1:0]          acc_r_d, acc_i_d;
  logic [TPP-1:0][DATA_WIDTH-1:0] xr_q, xi_q;
  logic                           rd_en_q, wr_en_q;
  logic [DATA_WIDTH-1:0]          real_out_q, imag_out_q;

  logic                           in_empty_s, out_full_s;
  logic [KW-1:0]                  k_s;
  logic [DATA_WIDTH-1:0]          hr_s, hi_s, xr_s, xi_s;

  assign in_empty_s = io.i_empty | io.q_empty;
  assign out_full_s = io.real_full | io.imag_full;

  // Complex MAC for the current phase/tap: coefficient k = phase + INTERP*tap.
  always_comb begin
    k_s     = KW'(phase_q) + KW'(INTERP) * KW'(tap_q);
    hr_s    = REAL_COEFF[k_s];
    hi_s    = IMAG_COEFF[k_s];
    xr_s    = xr_q[tap_q];
    xi_s    = xi_q[tap_q];
    acc_r_d = acc_r_q + mul_q(hr_s, xr_s) - mul_q(hi_s, xi_s);
    acc_i_d = acc_i_q + mul_q(hr_s, xi_s) + mul_q(hi_s, xr_s);
  end

  // Control FSM with history, accumulators and registered FIFO strobes/data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_READ;
      phase_q    <= '0;
      tap_q      <= '0;
      acc_r_q    <= '0;
      acc_i_q    <= '0;
      xr_q       <= '0;
      xi_q       <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      real_out_q <= '0;
      imag_out_q <= '0;
    end else begin
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      real_out_q <= '0;
      imag_out_q <= '0;
      case (state_q)
        ST_READ: begin
          if (!in_empty_s) begin
            rd_en_q <= 1'b1;
            for (int n = TPP - 1; n > 0; n--) begin
              xr_q[n] <= xr_q[n-1];
              xi_q[n] <= xi_q[n-1];
            end
            xr_q[0] <= io.i_in;
            xi_q[0] <= io.q_in;
            phase_q <= '0;
            tap_q   <= '0;
            acc_r_q <= '0;
            acc_i_q <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_r_q <= acc_r_d;
          acc_i_q <= acc_i_d;
          if (tap_q == TW'(TPP - 1)) begin
            state_q <= ST_WRITE;
          end else begin
            tap_q <= tap_q + TW'(1);
          end
        end
        ST_WRITE: begin
          // A full output FIFO freezes the phase and accumulator until it drains.
          if (!out_full_s) begin
            wr_en_q    <= 1'b1;
            real_out_q <= acc_r_q;
            imag_out_q <= acc_i_q;
            if (phase_q == PW'(INTERP - 1)) begin
              state_q <= ST_READ;
            end else begin
              phase_q <= phase_q + PW'(1);
              tap_q   <= '0;
              acc_r_q <= '0;
              acc_i_q <= '0;
              state_q <= ST_RUN;
            end
          end
        end
        default: state_q <= ST_READ;
      endcase
    end
  end

  assign io.i_rd_en    = rd_en_q;
  assign io.q_rd_en    = rd_en_q;
  assign io.real_wr_en = wr_en_q;
  assign io.imag_wr_en = wr_en_q;
  assign io.real_out   = real_out_q;
  assign io.imag_out   = imag_out_q;

endmodule
